ltc2308_adc_ctrl: RTL

//  Serial front end for the LTC2308 8-ch 12-bit ADC, driving the adc_CONVST/adc_SCK/adc_SDI/adc_SDO conduit of soc_system.

---
 rtl/ltc2308_adc_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ltc2308_adc_ctrl.sv
// LTC2308 serial front end: round-robins enabled channels, shifts config out on SDI
// and the previous frame's result in on SDO, and publishes tagged samples on valid/ready.
//  state | meaning
//  IDLE  | no conversion in flight
//  PULSE | CONVST held high
//  WAIT  | conversion time, CONVST low
//  SHIFT | 12 SCK periods: config out, result in
//  GAP   | quiet time after the last SCK edge
module ltc2308_adc_ctrl #(
  parameter int SCK_HALF      = 2,
  parameter int CONVST_CYCLES = 3,
  parameter int CONV_CYCLES   = 80,
  parameter int GAP_CYCLES    = 4,
  parameter bit UNIPOLAR      = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  output logic        adc_CONVST,
  output logic        adc_SCK,
  output logic        adc_SDI,
  input  logic        adc_SDO,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        overrun,
  output logic        busy
);

  localparam int M1      = (SCK_HALF > CONVST_CYCLES) ? SCK_HALF : CONVST_CYCLES;
  localparam int M2      = (CONV_CYCLES > GAP_CYCLES) ? CONV_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, PULSE, WAIT, SHIFT, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_idx;
  logic [2:0]      ch_cur;
  logic [2:0]      ch_prev;
  logic            first_frame;
  logic [11:0]     shreg;
  logic [5:0]      cfg_sh;
  logic [5:0]      cfg;

  assign cfg = {1'b1, ch_cur[0], ch_cur[2], ch_cur[1], UNIPOLAR, 1'b0};

  // Next set bit of the mask above cur (wrapping), or the lowest set bit when from_start.
  function automatic logic [2:0] pick_ch(input logic [7:0] mask, input logic [2:0] cur,
                                         input logic from_start);
    logic [7:0] m;
    logic [2:0] c;
    logic       found;
    m       = (mask == 8'h00) ? 8'h01 : mask;
    pick_ch = 3'd0;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = from_start ? 3'(i) : 3'(cur + 3'(i + 1));
      if (!found && m[c]) begin
        pick_ch = c;
        found   = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      ch_cur       <= '0;
      ch_prev      <= '0;
      first_frame  <= 1'b1;
      shreg        <= '0;
      cfg_sh       <= '0;
      adc_CONVST   <= 1'b0;
      adc_SCK      <= 1'b0;
      adc_SDI      <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (sample_valid && sample_ready) sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= PULSE;
            busy        <= 1'b1;
            adc_CONVST  <= 1'b1;
            cnt         <= CW'(CONVST_CYCLES - 1);
            ch_prev     <= ch_cur;
            ch_cur      <= pick_ch(ch_mask, ch_cur, 1'b1);
            first_frame <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state      <= WAIT;
            adc_CONVST <= 1'b0;
            cnt        <= CW'(CONV_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= SHIFT;
            cnt     <= CW'(SCK_HALF - 1);
            bit_idx <= '0;
            adc_SDI <= cfg[5];
            cfg_sh  <= {cfg[4:0], 1'b0};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!adc_SCK) begin
            adc_SCK <= 1'b1;
            shreg   <= {shreg[10:0], adc_SDO};
            cnt     <= CW'(SCK_HALF - 1);
          end else begin
            adc_SCK <= 1'b0;
            if (bit_idx == 4'd11) begin
              state   <= GAP;
              adc_SDI <= 1'b0;
              cnt     <= CW'(GAP_CYCLES - 1);
              // The first frame after IDLE carries a stale conversion; drop it silently.
              if (!first_frame) begin
                if (!sample_valid || sample_ready) begin
                  sample_valid <= 1'b1;
                  sample_data  <= shreg;
                  sample_ch    <= ch_prev;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              adc_SDI <= cfg_sh[5];
              cfg_sh  <= {cfg_sh[4:0], 1'b0};
              cnt     <= CW'(SCK_HALF - 1);
            end
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (enable) begin
              state       <= PULSE;
              adc_CONVST  <= 1'b1;
              cnt         <= CW'(CONVST_CYCLES - 1);
              ch_prev     <= ch_cur;
              ch_cur      <= pick_ch(ch_mask, ch_cur, 1'b0);
              first_frame <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
